// File: rtl/slib_input_filter_sync.sv
// Multi-channel input synchroniser with a per-channel stability filter and
// registered rise/fall/change strobes (UART modem-status and RXD inputs).
module slib_input_filter_sync #(
  parameter int               WIDTH    = 4,
  parameter int               STAGES   = 2,
  parameter int               FILT_LEN = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             CHG
);

  localparam int            CW       = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [WIDTH-1:0] sync_p0 [STAGES];
  logic [WIDTH-1:0] s_p1;
  logic [CW-1:0]    cnt_p1 [WIDTH];
  logic [WIDTH-1:0] take_p1;
  logic [WIDTH-1:0] rise_nxt_p1;
  logic [WIDTH-1:0] fall_nxt_p1;

  // Stage 0: free-running synchroniser chain, independent of CE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < STAGES; k++) sync_p0[k] <= RST_VAL;
    end else begin
      sync_p0[0] <= D;
      for (int k = 1; k < STAGES; k++) sync_p0[k] <= sync_p0[k-1];
    end
  end

  assign s_p1 = sync_p0[STAGES-1];

  // Stage 1: a channel commits its new level on the enabled sample that
  // completes FILT_LEN consecutive disagreeing samples
  always_comb begin
    take_p1     = '0;
    rise_nxt_p1 = '0;
    fall_nxt_p1 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      take_p1[i] = (s_p1[i] != Q[i]) && CE && (cnt_p1[i] == CNT_LAST);
    end
    rise_nxt_p1 = take_p1 & s_p1;
    fall_nxt_p1 = take_p1 & ~s_p1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < WIDTH; i++) cnt_p1[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((s_p1[i] == Q[i]) || take_p1[i]) begin
          cnt_p1[i] <= '0;
        end else if (CE) begin
          cnt_p1[i] <= cnt_p1[i] + 1'b1;
        end
      end
    end
  end

  // Stage 2: level and strobes register on the same edge so pulses line up
  // with the first cycle of the new Q
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q    <= RST_VAL;
      RISE <= '0;
      FALL <= '0;
      CHG  <= 1'b0;
    end else begin
      Q    <= (Q & ~take_p1) | (s_p1 & take_p1);
      RISE <= rise_nxt_p1;
      FALL <= fall_nxt_p1;
      CHG  <= |(rise_nxt_p1 | fall_nxt_p1);
    end
  end

endmodule

// File: tb/tb_slib_input_filter_sync.sv
// Bench for slib_input_filter_sync: directed scenarios plus randomized traffic
// against a delay-line / run-length reference model.
module tb_slib_input_filter_sync;

  localparam int         W  = 4;
  localparam int         ST = 2;
  localparam int         FL = 3;
  localparam logic [3:0] RV = 4'b1010;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CE;
  logic [3:0] D;
  logic [3:0] Q, RISE, FALL;
  logic       CHG;

  int checks = 0;
  int fails  = 0;

  // reference model state
  logic [3:0] dq [$];
  logic [3:0] mq, mr, mf;
  logic       mc;
  int         run [W];

  always #5 CLK = ~CLK;

  slib_input_filter_sync #(
    .WIDTH(W), .STAGES(ST), .FILT_LEN(FL), .RST_VAL(RV)
  ) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .D(D),
    .Q(Q), .RISE(RISE), .FALL(FALL), .CHG(CHG)
  );

  task automatic model_reset();
    dq.delete();
    repeat (ST) dq.push_back(RV);
    mq = RV; mr = '0; mf = '0; mc = 1'b0;
    foreach (run[i]) run[i] = 0;
  endtask

  // D reaches the filter ST edges after it is sampled; the filter counts a run
  // of enabled samples that disagree with the output level.
  task automatic model_edge();
    logic [3:0] s, nr, nf;
    if (RST) begin
      model_reset();
      return;
    end
    s = dq.pop_front();
    dq.push_back(D);
    nr = '0; nf = '0;
    for (int i = 0; i < W; i++) begin
      if (s[i] == mq[i]) run[i] = 0;
      else if (CE) begin
        run[i]++;
        if (run[i] == FL) begin
          run[i] = 0;
          mq[i]  = s[i];
          if (s[i]) nr[i] = 1'b1; else nf[i] = 1'b1;
        end
      end
    end
    mr = nr; mf = nf; mc = |(nr | nf);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".Q"},    {28'd0, Q},    {28'd0, mq});
    chk({tag, ".RISE"}, {28'd0, RISE}, {28'd0, mr});
    chk({tag, ".FALL"}, {28'd0, FALL}, {28'd0, mf});
    chk({tag, ".CHG"},  {31'd0, CHG},  {31'd0, mc});
  endtask

  task automatic step(string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int n, nchg, cyc;
    logic [3:0] rise_seen;
    logic       ce_at_edge, prev_q2;

    // reset with D toggling
    RST = 1'b1; CE = 1'b1; D = 4'b0000;
    model_reset();
    #2;
    check_all("reset");
    chk("reset_q_const", {28'd0, Q}, 32'hA);
    repeat (4) begin
      D = 4'($urandom);
      step("rst_hold");
    end
    D = RV;
    RST = 1'b0;
    repeat (4) step("release");

    // settle every channel to 0
    D = 4'b0000;
    repeat (8) step("settle0");

    // single step on channel 0: STAGES+FILT_LEN edges
    D = 4'b0001;
    n = 0;
    do begin
      step("step");
      n++;
    end while (Q[0] !== 1'b1 && n < 20);
    chk("step_lat", n, 5);
    chk("step_rise", {28'd0, RISE}, 32'h1);
    chk("step_chg", {31'd0, CHG}, 32'h1);
    step("step_after");
    chk("step_rise_done", {28'd0, RISE}, 32'h0);

    // glitch on channel 1 shorter than the filter length
    D = 4'b0011;
    repeat (2) step("glitch_hi");
    D = 4'b0001;
    repeat (8) step("glitch_lo");
    chk("glitch_q1", {31'd0, Q[1]}, 32'h0);

    // CE every 4th cycle: level only moves on enabled edges
    D = 4'b0101;
    cyc = 0;
    repeat (30) begin
      CE = (cyc % 4 == 0);
      ce_at_edge = CE;
      prev_q2 = Q[2];
      step("ce_gate");
      if (!ce_at_edge) chk("ce_hold", {31'd0, Q[2]}, {31'd0, prev_q2});
      cyc++;
    end
    chk("ce_q2", {31'd0, Q[2]}, 32'h1);
    CE = 1'b1;

    // simultaneous edges, channel 3 only a one-cycle blip
    D = 4'b0000;
    repeat (8) step("settle1");
    D = 4'b1111;
    step("simul_a");
    D = 4'b0111;
    nchg = 0; rise_seen = '0;
    repeat (10) begin
      step("simul");
      if (CHG) begin nchg++; rise_seen = RISE; end
    end
    chk("simul_chg_count", nchg, 1);
    chk("simul_rise", {28'd0, rise_seen}, 32'h7);
    chk("simul_q", {28'd0, Q}, 32'h7);

    // asynchronous reset while channel 0 is mid-filter
    D = 4'b0000;
    repeat (8) step("settle2");
    D = 4'b0001;
    repeat (4) step("midfilt");
    RST = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_q", {28'd0, Q}, 32'hA);
    repeat (2) step("async_rst_hold");
    RST = 1'b0;
    n = 0;
    do begin
      step("post_rst");
      n++;
    end while (Q[0] !== 1'b1 && n < 20);
    chk("post_rst_lat", n, 5);

    // randomized traffic with random CE and occasional async resets
    repeat (400) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 5) == 0) D[i] = ~D[i];
      CE = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) begin
        RST = 1'b1;
        #1;
        model_reset();
        check_all("rand_rst");
        step("rand_rst_hold");
        RST = 1'b0;
      end
      step("rand");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
